// File: rtl/line_pack_buffer_if.sv
// line_pack_buffer_if: beat-in / line-out handshake bundle for line_pack_buffer.
// The "slave" modport is the packer itself; "master" is the surrounding pipeline
// (upstream encoder plus downstream line consumer).
interface line_pack_buffer_if #(
  parameter int LANES          = 2,
  parameter int WORD_W         = 32,
  parameter int CODE_W         = 34,
  parameter int WORDS_PER_LINE = 4,
  parameter int LEN_W          = $clog2(CODE_W + 1),
  parameter int LINE_W         = WORD_W * WORDS_PER_LINE,
  parameter int CNT_W          = $clog2(LINE_W + 1)
);
  logic                    i_valid;
  logic                    o_ready;
  logic [LANES*CODE_W-1:0] i_code;
  logic [LANES*LEN_W-1:0]  i_len;
  logic [LANES*WORD_W-1:0] i_raw;
  logic                    o_valid;
  logic                    i_ready;
  logic [LINE_W-1:0]       o_data;
  logic [CNT_W-1:0]        o_bits;
  logic                    o_raw;

  modport slave (
    input  i_valid, i_code, i_len, i_raw, i_ready,
    output o_ready, o_valid, o_data, o_bits, o_raw
  );

  modport master (
    output i_valid, i_code, i_len, i_raw, i_ready,
    input  o_ready, o_valid, o_data, o_bits, o_raw
  );
endinterface

// File: rtl/line_pack_buffer.sv
// line_pack_buffer: bit-packs LANES variable-length codes per beat into one
// compressed line per uncompressed cache line, falling back to the raw line
// when the packed form would not be smaller.
// Optional feature macro: LINE_PACK_STATS_EN adds o_lines_total / o_lines_raw.
module line_pack_buffer #(
  parameter int LANES          = 2,
  parameter int WORD_W         = 32,
  parameter int CODE_W         = 34,
  parameter int WORDS_PER_LINE = 4,
  parameter int LEN_W          = $clog2(CODE_W + 1),
  parameter int LINE_W         = WORD_W * WORDS_PER_LINE,
  parameter int CNT_W          = $clog2(LINE_W + 1)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  line_pack_buffer_if.slave   bus
`ifdef LINE_PACK_STATS_EN
  ,
  output logic [31:0]         o_lines_total,
  output logic [31:0]         o_lines_raw
`endif
);

  localparam int BEATS  = WORDS_PER_LINE / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int FILL_W = CNT_W + 1;

  typedef enum logic [0:0] {ACCUM = 1'b0, EMIT = 1'b1} state_t;

  state_t             state;
  state_t             state_next;
  logic [BEAT_W-1:0]  beat;
  logic [FILL_W-1:0]  fill;
  logic [FILL_W-1:0]  fill_next;
  logic               ovf;
  logic               ovf_next;
  logic [LINE_W-1:0]  comp_buf;
  logic [LINE_W-1:0]  comp_next;
  logic [LINE_W-1:0]  raw_buf;
  logic [LINE_W-1:0]  raw_next;
  logic [LINE_W-1:0]  data_q;
  logic [CNT_W-1:0]   bits_q;
  logic               raw_q;
  logic               valid_q;
  logic               ready;
  logic               accept;
  logic               last_beat;
  logic               line_done;
  logic [LEN_W-1:0]   len_k;
  logic [LEN_W-1:0]   len_eff;
  logic [CODE_W-1:0]  code_k;
  logic [FILL_W-1:0]  sum_k;

  localparam logic [CODE_W-1:0] CODE_ONES = {CODE_W{1'b1}};

  assign accept    = bus.i_valid & ready;
  assign last_beat = (beat == BEAT_W'(BEATS - 1));
  assign line_done = valid_q & bus.i_ready;

  assign bus.o_ready = ready;
  assign bus.o_valid = valid_q;
  assign bus.o_data  = data_q;
  assign bus.o_bits  = bits_q;
  assign bus.o_raw   = raw_q;

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state and beat-side ready; ready is held low while reset is asserted.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    case (state)
      ACCUM: begin
        ready = ~i_reset;
        if (accept && last_beat) begin
          state_next = EMIT;
        end else begin
          state_next = ACCUM;
        end
      end
      EMIT: begin
        if (bus.i_ready) begin
          state_next = ACCUM;
        end else begin
          state_next = EMIT;
        end
      end
      default: begin
        state_next = ACCUM;
      end
    endcase
  end

  // Append this beat's lanes (lane 0 first) to the packed buffer and capture raw words.
  // An append that would reach the line width sets the sticky overflow and is dropped.
  always_comb begin
    fill_next = fill;
    ovf_next  = ovf;
    comp_next = comp_buf;
    raw_next  = raw_buf;
    len_k     = '0;
    len_eff   = '0;
    code_k    = '0;
    sum_k     = '0;
    for (int k = 0; k < LANES; k++) begin
      len_k   = bus.i_len[k*LEN_W +: LEN_W];
      len_eff = (len_k > LEN_W'(CODE_W)) ? LEN_W'(CODE_W) : len_k;
      code_k  = bus.i_code[k*CODE_W +: CODE_W] & (CODE_ONES >> (CODE_W - int'(len_eff)));
      sum_k   = fill_next + FILL_W'(len_eff);
      if (ovf_next) begin
        fill_next = fill_next;
      end else if (sum_k >= FILL_W'(LINE_W)) begin
        ovf_next = 1'b1;
      end else begin
        comp_next = comp_next | (LINE_W'(code_k) << fill_next);
        fill_next = sum_k;
      end
      raw_next[(int'(beat) * LANES + k) * WORD_W +: WORD_W] = bus.i_raw[k*WORD_W +: WORD_W];
    end
  end

  // Line accumulation state and registered line outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      beat     <= '0;
      fill     <= '0;
      ovf      <= 1'b0;
      comp_buf <= '0;
      raw_buf  <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      bits_q   <= '0;
      raw_q    <= 1'b0;
    end else if (line_done) begin
      beat     <= '0;
      fill     <= '0;
      ovf      <= 1'b0;
      comp_buf <= '0;
      raw_buf  <= '0;
      valid_q  <= 1'b0;
    end else if (accept) begin
      fill     <= fill_next;
      ovf      <= ovf_next;
      comp_buf <= comp_next;
      raw_buf  <= raw_next;
      if (last_beat) begin
        beat    <= '0;
        valid_q <= 1'b1;
        data_q  <= ovf_next ? raw_next : comp_next;
        bits_q  <= ovf_next ? CNT_W'(LINE_W) : fill_next[CNT_W-1:0];
        raw_q   <= ovf_next;
      end else begin
        beat    <= beat + BEAT_W'(1);
      end
    end else begin
      beat <= beat;
    end
  end

`ifdef LINE_PACK_STATS_EN
  // Handed-off line counters, wrapping modulo 2^32.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_lines_total <= 32'd0;
      o_lines_raw   <= 32'd0;
    end else if (line_done) begin
      o_lines_total <= o_lines_total + 32'd1;
      if (raw_q) begin
        o_lines_raw <= o_lines_raw + 32'd1;
      end else begin
        o_lines_raw <= o_lines_raw;
      end
    end else begin
      o_lines_total <= o_lines_total;
      o_lines_raw   <= o_lines_raw;
    end
  end
`endif

endmodule

// File: tb/tb_line_pack_buffer.sv
// tb_line_pack_buffer: directed and random lines for line_pack_buffer, checked
// against a bit-level reference model of the packing rules.
module tb_line_pack_buffer;
  localparam int LANES  = 2;
  localparam int WORD_W = 32;
  localparam int CODE_W = 34;
  localparam int WPL    = 4;
  localparam int LEN_W  = 6;
  localparam int LINE_W = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;

  line_pack_buffer_if #(.LANES(LANES), .WORD_W(WORD_W), .CODE_W(CODE_W),
                        .WORDS_PER_LINE(WPL)) bus ();

`ifdef LINE_PACK_STATS_EN
  logic [31:0] lines_total;
  logic [31:0] lines_raw;
`endif

  line_pack_buffer #(.LANES(LANES), .WORD_W(WORD_W), .CODE_W(CODE_W),
                     .WORDS_PER_LINE(WPL)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
`ifdef LINE_PACK_STATS_EN
    ,
    .o_lines_total (lines_total),
    .o_lines_raw   (lines_raw)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int exp_total = 0;
  int exp_raw_cnt = 0;

  int          lens_a [WPL];
  logic [33:0] codes_a[WPL];
  logic [31:0] raws_a [WPL];

  logic [127:0] exp_data;
  int           exp_bits;
  logic         exp_rawf;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: total effective length decides raw vs packed; packed bits placed one by one.
  task automatic model();
    int total;
    int off;
    int l;
    total = 0;
    for (int w = 0; w < WPL; w++) total += (lens_a[w] > CODE_W) ? CODE_W : lens_a[w];
    exp_data = '0;
    if (total >= LINE_W) begin
      exp_rawf = 1'b1;
      exp_bits = LINE_W;
      for (int w = 0; w < WPL; w++)
        for (int j = 0; j < WORD_W; j++) exp_data[w*WORD_W + j] = raws_a[w][j];
    end else begin
      exp_rawf = 1'b0;
      exp_bits = total;
      off = 0;
      for (int w = 0; w < WPL; w++) begin
        l = (lens_a[w] > CODE_W) ? CODE_W : lens_a[w];
        for (int j = 0; j < l; j++) exp_data[off + j] = codes_a[w][j];
        off += l;
      end
    end
  endtask

  task automatic drive_beat(input int b);
    int w;
    bus.i_valid = 1'b1;
    for (int k = 0; k < LANES; k++) begin
      w = b * LANES + k;
      bus.i_code[k*CODE_W +: CODE_W] = codes_a[w];
      bus.i_len[k*LEN_W +: LEN_W]    = 6'(lens_a[w]);
      bus.i_raw[k*WORD_W +: WORD_W]  = raws_a[w];
    end
  endtask

  task automatic send_beats();
    for (int b = 0; b < WPL / LANES; b++) begin
      drive_beat(b);
      check("ready_beat", 128'(bus.o_ready), 128'(1'b1));
      @(posedge clk); #1;
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic check_line(input string tag);
    model();
    check({tag, "_valid"}, 128'(bus.o_valid), 128'(1'b1));
    check({tag, "_data"},  bus.o_data, exp_data);
    check({tag, "_bits"},  128'(bus.o_bits), 128'(exp_bits));
    check({tag, "_raw"},   128'(bus.o_raw), 128'(exp_rawf));
  endtask

  task automatic handshake();
    bus.i_ready = 1'b1;
    check("ready_in_emit", 128'(bus.o_ready), 128'(1'b0));
    @(posedge clk); #1;
    bus.i_ready = 1'b0;
    exp_total++;
    if (exp_rawf) exp_raw_cnt++;
    check("valid_after_hs", 128'(bus.o_valid), 128'(1'b0));
    check("ready_after_hs", 128'(bus.o_ready), 128'(1'b1));
  endtask

  task automatic set_first_line();
    lens_a  = '{6, 3, 0, 8};
    codes_a = '{34'h3_FFFF_FFAA, 34'h0_0000_00FD, 34'h2_DEAD_BEEF, 34'h1_0000_00FF};
    raws_a  = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_code  = '0;
    bus.i_len   = '0;
    bus.i_raw   = '0;

    // Reset state.
    @(posedge clk); #1;
    check("rst_ready", 128'(bus.o_ready), 128'(1'b0));
    check("rst_valid", 128'(bus.o_valid), 128'(1'b0));
    check("rst_data",  bus.o_data, 128'(0));
    check("rst_bits",  128'(bus.o_bits), 128'(0));
    check("rst_raw",   128'(bus.o_raw), 128'(1'b0));
`ifdef LINE_PACK_STATS_EN
    check("rst_total", 128'(lines_total), 128'(0));
`endif
    rst = 1'b0;
    #1;
    check("post_rst_ready", 128'(bus.o_ready), 128'(1'b1));

    // Compressed line with garbage above each code length.
    set_first_line();
    send_beats();
    check_line("comp");
    check("comp_bits_abs", 128'(bus.o_bits), 128'(17));
    check("comp_data_abs", bus.o_data, 128'h1FF6A);
    handshake();

    // Overflow to raw.
    lens_a  = '{34, 34, 34, 34};
    codes_a = '{34'h3_0000_0001, 34'h2_0000_0002, 34'h1_0000_0003, 34'h0_0000_0004};
    raws_a  = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    send_beats();
    check_line("ovf");
    check("ovf_data_abs", bus.o_data, 128'h44444444_33333333_22222222_11111111);
    handshake();

    // Boundary: exactly the line width falls back to raw.
    lens_a = '{32, 32, 32, 32};
    send_beats();
    check_line("eq128");
    check("eq128_raw_abs", 128'(bus.o_raw), 128'(1'b1));
    handshake();

    // Boundary: one bit short stays compressed.
    lens_a = '{32, 32, 32, 31};
    send_beats();
    check_line("127");
    check("127_bits_abs", 128'(bus.o_bits), 128'(127));
    handshake();

    // Over-long length field saturates at the code width.
    lens_a = '{63, 0, 40, 1};
    send_beats();
    check_line("satlen");
    handshake();

    // Backpressure: line held stable, no beats consumed while toggling i_valid.
    set_first_line();
    send_beats();
    check_line("bp");
    for (int i = 0; i < 5; i++) begin
      bus.i_valid = i[0] ? 1'b0 : 1'b1;
      bus.i_len   = 12'(i + 1);
      bus.i_code  = {$urandom, $urandom, $urandom};
      @(posedge clk); #1;
      check("bp_valid", 128'(bus.o_valid), 128'(1'b1));
      check("bp_data",  bus.o_data, exp_data);
      check("bp_bits",  128'(bus.o_bits), 128'(exp_bits));
      check("bp_ready", 128'(bus.o_ready), 128'(1'b0));
    end
    bus.i_valid = 1'b0;
    handshake();
    set_first_line();
    send_beats();
    check_line("after_bp");
    handshake();

    // Reset mid-line discards the partial line and the counters.
    lens_a = '{20, 20, 20, 20};
    drive_beat(0);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready", 128'(bus.o_ready), 128'(1'b0));
    check("midrst_valid", 128'(bus.o_valid), 128'(1'b0));
    rst = 1'b0;
    exp_total = 0;
    exp_raw_cnt = 0;
    #1;
    set_first_line();
    send_beats();
    check_line("midrst");
    check("midrst_bits_abs", 128'(bus.o_bits), 128'(17));
    check("midrst_data_abs", bus.o_data, 128'h1FF6A);
    handshake();

    // Random lines with random downstream stall.
    for (int n = 0; n < 40; n++) begin
      for (int w = 0; w < WPL; w++) begin
        lens_a[w]  = (n % 3 == 0) ? int'($urandom_range(28, 40)) : int'($urandom_range(0, 63));
        codes_a[w] = {$urandom, $urandom} & 34'h3_FFFF_FFFF;
        raws_a[w]  = $urandom;
      end
      send_beats();
      check_line("rand");
      for (int s = 0; s < int'($urandom_range(0, 3)); s++) begin
        bus.i_valid = 1'($urandom);
        @(posedge clk); #1;
        check("rand_stall_data", bus.o_data, exp_data);
        check("rand_stall_ready", 128'(bus.o_ready), 128'(1'b0));
      end
      bus.i_valid = 1'b0;
      handshake();
    end

`ifdef LINE_PACK_STATS_EN
    check("stats_total", 128'(lines_total), 128'(exp_total));
    check("stats_raw",   128'(lines_raw),   128'(exp_raw_cnt));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/line_pack_buffer.md
# line_pack_buffer

Parametrised line-assembly stage that sits after the dictionary match/encode stages of the compressor pipeline. It accepts LANES variable-length codes per beat, plus the matching raw words, and bit-packs them into one compressed line per uncompressed cache line. When the packed result is no smaller than the raw line, it falls back to emitting the raw line. Output is one line per ready/valid transfer, tagged with its bit length and a raw/compressed flag.

## Interface
- LANES, 2, words/codes accepted per beat (≥1)
- WORD_W, 32, raw word width
- CODE_W, 34, max code width per lane (code + literal)
- WORDS_PER_LINE, 4, words per uncompressed line; must be a multiple of LANES
- LEN_W, $clog2(CODE_W+1), per-lane length field width
- LINE_W, WORD_W*WORDS_PER_LINE (derived), line width
- CNT_W, $clog2(LINE_W+1) (derived), bit-count width
- i_clk  in  1  clock
- i_reset  in  1  reset; one clock, synchronous, active-high
- i_valid  in  1  input beat valid
- o_ready  out  1  beat accepted when i_valid & o_ready
- i_code  in  LANES*CODE_W  lane k code at [k*CODE_W +: CODE_W], right-aligned
- i_len  in  LANES*LEN_W  lane k code length in bits
- i_raw  in  LANES*WORD_W  lane k raw word
- o_valid  out  1  line available
- i_ready  in  1  downstream accepts line
- o_data  out  LINE_W  packed line, LSB-first
- o_bits  out  CNT_W  valid bits in o_data
- o_raw  out  1  1 = o_data is the raw line

## Operation
- BEATS = WORDS_PER_LINE/LANES beats form one line; a beat counter tracks position.
- FSM: ACCUM, EMIT. In ACCUM, o_ready=1 and o_valid=0. In EMIT, o_ready=0 and o_valid=1.
- Packing, per accepted beat, lane 0 first:
  - code bits [len-1:0] are ORed into the compressed buffer at offset fill, then fill += len;
  - bits of i_code above len are masked off;
  - len > CODE_W is treated as CODE_W; len = 0 contributes nothing.
- fill is held in CNT_W+1 bits. Once fill would reach ≥ LINE_W, the sticky overflow flag is set, and further compressed appends are suppressed for the rest of the line.
- Raw words are stored at [(beat*LANES+k)*WORD_W +: WORD_W] regardless of overflow.
- When the last beat is accepted, go to EMIT with:
  - overflow (total ≥ LINE_W): o_data = raw line, o_bits = LINE_W, o_raw = 1;
  - otherwise: o_data = compressed buffer (bits ≥ fill are zero), o_bits = fill, o_raw = 0.
- EMIT with i_ready=1: return to ACCUM. Clear fill, overflow, both buffers and the beat counter.
- i_valid while o_ready=0 is ignored; no beat is consumed.

## Timing
- Reset:
  - state = ACCUM; buffers, fill, counter and overflow cleared;
  - o_valid=0, o_data=0, o_bits=0, o_raw=0;
  - o_ready=0 during the reset cycle and 1 from the first cycle after.
- Beat processing takes one cycle per beat, with no internal bubbles within a line.
- o_valid rises the cycle after the final beat handshake.
- o_data, o_bits and o_raw are registered and stable while o_valid=1 and i_ready=0.
- Line handshake: on the cycle o_valid & i_ready, o_ready is 0. ACCUM resumes on the next cycle.
- Peak throughput: one line per BEATS+1 cycles.
- Reset mid-line discards the partial line. The next accepted beat starts at offset 0, beat 0.

## Configuration
- LINE_PACK_STATS_EN defined adds:
  - o_lines_total (out, 32): lines handed off;
  - o_lines_raw (out, 32): lines handed off with o_raw=1;
  - both increment on the o_valid & i_ready cycle, wrap modulo 2^32, and reset to 0.
- LINE_PACK_STATS_EN undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- Compressed line (defaults), two beats:
  - beat 0: lane0 code 0x2A len 6, lane1 code 0x5 len 3; beat 1: lane0 len 0, lane1 code 0xFF len 8;
  - expect o_bits=17, o_data=0x1FF6A, o_raw=0.
- Overflow: all four lanes len 34, raw words 0x11111111..0x44444444.
  - Expect o_raw=1, o_bits=128, o_data=0x44444444_33333333_22222222_11111111.
- Boundary: lengths 32,32,32,32 (sum exactly 128).
  - Expect o_raw=1, o_bits=128. Sum 127 → o_raw=0, o_bits=127.
- Backpressure: hold i_ready=0 for 5 cycles in EMIT while toggling i_valid.
  - Expect o_valid, o_data and o_bits stable, o_ready=0, and no beat consumed; the next line packs from offset 0.
- Reset mid-line: assert i_reset after beat 0, then send a fresh two-beat line of 6+3+0+8 bits.
  - Expect o_bits=17 with the same o_data as the first scenario.
- With LINE_PACK_STATS_EN: send three lines (two compressed, one overflow).
  - Expect o_lines_total=3, o_lines_raw=1.
